// File: rtl/rv_plic_target_ctrl.sv
// PLIC per-target claim/complete controller: picks the highest-priority eligible
// source, answers claim reads, retires completes and tracks outstanding claims.
module rv_plic_target_ctrl #(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned PRIOW    = 3,
  parameter int unsigned SRCW     = 6,
  parameter int unsigned MAX_OUT  = 4,
  localparam int unsigned CNTW    = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_SOURCE-1:0]       ip_i,
  input  logic [N_SOURCE-1:0]       ie_i,
  input  logic [N_SOURCE*PRIOW-1:0] prio_i,
  input  logic [PRIOW-1:0]          threshold_i,
  input  logic                      claim_re_i,
  input  logic                      complete_we_i,
  input  logic [SRCW-1:0]           complete_id_i,
  output logic                      irq_o,
  output logic [SRCW-1:0]           irq_id_o,
  output logic                      claim_rvalid_o,
  output logic [SRCW-1:0]           claim_rid_o,
  output logic [N_SOURCE-1:0]       claim_o,
  output logic [N_SOURCE-1:0]       complete_o,
  output logic                      complete_err_o,
  output logic [CNTW-1:0]           out_cnt_o
);

  logic [N_SOURCE-1:0] active_q, active_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [PRIOW-1:0]    best_prio_c;
  logic [SRCW-1:0]     best_id_c;
  logic [N_SOURCE-1:0] claim_oh_c, cmp_oh_c;
  logic                claim_ok_c, cmp_ok_c;

  // Strict '>' on the running best keeps ties at the lowest index.
  always_comb begin
    best_prio_c = '0;
    best_id_c   = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      if (ip_i[i] && ie_i[i] && !active_q[i] &&
          (prio_i[i*PRIOW +: PRIOW] > threshold_i) &&
          (prio_i[i*PRIOW +: PRIOW] > best_prio_c)) begin
        best_prio_c = prio_i[i*PRIOW +: PRIOW];
        best_id_c   = SRCW'(i + 1);
      end
    end
  end

  // One-hot decode of the claim candidate and the completed ID; ID 0 and
  // out-of-range IDs decode to an all-zero mask.
  always_comb begin
    claim_oh_c = '0;
    cmp_oh_c   = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      claim_oh_c[i] = (irq_id_o == SRCW'(i + 1));
      cmp_oh_c[i]   = (complete_id_i == SRCW'(i + 1));
    end
  end

  always_comb begin
    claim_ok_c = claim_re_i && (irq_id_o != '0) && ((claim_oh_c & active_q) == '0) &&
                 (cnt_q < CNTW'(MAX_OUT));
    cmp_ok_c   = complete_we_i && ((cmp_oh_c & active_q) != '0);
    active_d   = (active_q | (claim_ok_c ? claim_oh_c : '0)) & ~(cmp_ok_c ? cmp_oh_c : '0);
    cnt_d      = cnt_q + CNTW'(claim_ok_c) - CNTW'(cmp_ok_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q       <= '0;
      cnt_q          <= '0;
      irq_o          <= 1'b0;
      irq_id_o       <= '0;
      claim_rvalid_o <= 1'b0;
      claim_rid_o    <= '0;
      claim_o        <= '0;
      complete_o     <= '0;
      complete_err_o <= 1'b0;
    end else begin
      active_q       <= active_d;
      cnt_q          <= cnt_d;
      irq_o          <= (best_id_c != '0);
      irq_id_o       <= best_id_c;
      claim_rvalid_o <= claim_re_i;
      if (claim_re_i) begin
        claim_rid_o <= claim_ok_c ? irq_id_o : '0;
      end
      claim_o        <= claim_ok_c ? claim_oh_c : '0;
      complete_o     <= cmp_ok_c ? cmp_oh_c : '0;
      complete_err_o <= complete_we_i && !cmp_ok_c;
    end
  end

  assign out_cnt_o = cnt_q;

endmodule

// File: tb/tb_rv_plic_target_ctrl.sv
// Directed vector bench for rv_plic_target_ctrl with hand-computed expectations.
module tb_rv_plic_target_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ip, ie;
  logic [95:0] prio;
  logic [2:0]  thr;
  logic        cre, cwe;
  logic [5:0]  cid;
  logic        irq;
  logic [5:0]  irq_id;
  logic        rv;
  logic [5:0]  rid;
  logic [31:0] claim, cmp;
  logic        err;
  logic [2:0]  cnt;

  always #5 clk = ~clk;

  rv_plic_target_ctrl #(
    .N_SOURCE(32), .PRIOW(3), .SRCW(6), .MAX_OUT(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ip_i(ip), .ie_i(ie), .prio_i(prio),
    .threshold_i(thr), .claim_re_i(cre), .complete_we_i(cwe),
    .complete_id_i(cid), .irq_o(irq), .irq_id_o(irq_id),
    .claim_rvalid_o(rv), .claim_rid_o(rid), .claim_o(claim),
    .complete_o(cmp), .complete_err_o(err), .out_cnt_o(cnt)
  );

  typedef struct {
    string       nm;
    logic [31:0] ip, ie;
    logic [95:0] prio;
    logic [2:0]  thr;
    logic        cre, cwe;
    logic [5:0]  cid;
    logic        e_irq;
    logic [5:0]  e_id;
    logic        e_rv;
    logic [5:0]  e_rid;
    logic [31:0] e_claim, e_cmp;
    logic        e_err;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_irq, input logic [5:0] e_id,
                         input logic e_rv, input logic [5:0] e_rid, input logic [31:0] e_claim,
                         input logic [31:0] e_cmp, input logic e_err, input logic [2:0] e_cnt);
    chk({tag, ".irq"},   32'(irq),    32'(e_irq));
    chk({tag, ".id"},    32'(irq_id), 32'(e_id));
    chk({tag, ".rv"},    32'(rv),     32'(e_rv));
    chk({tag, ".rid"},   32'(rid),    32'(e_rid));
    chk({tag, ".claim"}, claim,       e_claim);
    chk({tag, ".cmp"},   cmp,         e_cmp);
    chk({tag, ".err"},   32'(err),    32'(e_err));
    chk({tag, ".cnt"},   32'(cnt),    32'(e_cnt));
  endtask

  task automatic add(input string nm, input logic [31:0] vip, input logic [31:0] vie,
                     input logic [95:0] vprio, input logic [2:0] vthr, input logic vcre,
                     input logic vcwe, input logic [5:0] vcid, input logic e_irq,
                     input logic [5:0] e_id, input logic e_rv, input logic [5:0] e_rid,
                     input logic [31:0] e_claim, input logic [31:0] e_cmp, input logic e_err,
                     input logic [2:0] e_cnt);
    vec_t v;
    v.nm = nm; v.ip = vip; v.ie = vie; v.prio = vprio; v.thr = vthr;
    v.cre = vcre; v.cwe = vcwe; v.cid = vcid;
    v.e_irq = e_irq; v.e_id = e_id; v.e_rv = e_rv; v.e_rid = e_rid;
    v.e_claim = e_claim; v.e_cmp = e_cmp; v.e_err = e_err; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic idle_strobes();
    cre = 1'b0; cwe = 1'b0; cid = 6'd0;
  endtask

  logic [95:0] p1, p2, p3;

  initial begin
    // prio[0]=2, prio[2]=5 / prio[1]=prio[2]=4 / prio[i]=i+1 for i<5
    p1 = '0; p1[2:0] = 3'd2; p1[8:6] = 3'd5;
    p2 = '0; p2[5:3] = 3'd4; p2[8:6] = 3'd4;
    p3 = '0;
    for (int i = 0; i < 5; i++) p3[i*3 +: 3] = 3'(i + 1);

    //  name        ip      ie      prio thr cre cwe cid   irq id rv rid claim   cmp     err cnt
    add("arb_hi",   32'h5,  32'h5,  p1, 3'd1, 0, 0, 6'd0,  1, 6'd3, 0, 6'd0, 32'h0,  32'h0,  0, 3'd0);
    add("arb_tie",  32'h6,  32'h6,  p2, 3'd0, 0, 0, 6'd0,  1, 6'd2, 0, 6'd0, 32'h0,  32'h0,  0, 3'd0);
    add("arb_thr",  32'h6,  32'h6,  p2, 3'd4, 0, 0, 6'd0,  0, 6'd0, 0, 6'd0, 32'h0,  32'h0,  0, 3'd0);
    add("arb_back", 32'h5,  32'h5,  p1, 3'd1, 0, 0, 6'd0,  1, 6'd3, 0, 6'd0, 32'h0,  32'h0,  0, 3'd0);
    add("claim1",   32'h5,  32'h5,  p1, 3'd1, 1, 0, 6'd0,  1, 6'd3, 1, 6'd3, 32'h4,  32'h0,  0, 3'd1);
    add("claim2",   32'h5,  32'h5,  p1, 3'd1, 1, 0, 6'd0,  1, 6'd1, 1, 6'd0, 32'h0,  32'h0,  0, 3'd1);
    add("hold",     32'h5,  32'h5,  p1, 3'd1, 0, 0, 6'd0,  1, 6'd1, 0, 6'd0, 32'h0,  32'h0,  0, 3'd1);
    add("cmp3",     32'h5,  32'h5,  p1, 3'd1, 0, 1, 6'd3,  1, 6'd1, 0, 6'd0, 32'h0,  32'h4,  0, 3'd0);
    add("rearb",    32'h5,  32'h5,  p1, 3'd1, 0, 0, 6'd0,  1, 6'd3, 0, 6'd0, 32'h0,  32'h0,  0, 3'd0);
    add("cmp3_dup", 32'h5,  32'h5,  p1, 3'd1, 0, 1, 6'd3,  1, 6'd3, 0, 6'd0, 32'h0,  32'h0,  1, 3'd0);
    add("cmp0",     32'h5,  32'h5,  p1, 3'd1, 0, 1, 6'd0,  1, 6'd3, 0, 6'd0, 32'h0,  32'h0,  1, 3'd0);
    add("cmp33",    32'h5,  32'h5,  p1, 3'd1, 0, 1, 6'd33, 1, 6'd3, 0, 6'd0, 32'h0,  32'h0,  1, 3'd0);
    add("m_cfg",    32'h1F, 32'h1F, p3, 3'd0, 0, 0, 6'd0,  1, 6'd5, 0, 6'd0, 32'h0,  32'h0,  0, 3'd0);
    add("m_c5",     32'h1F, 32'h1F, p3, 3'd0, 1, 0, 6'd0,  1, 6'd5, 1, 6'd5, 32'h10, 32'h0,  0, 3'd1);
    add("m_i5",     32'h1F, 32'h1F, p3, 3'd0, 0, 0, 6'd0,  1, 6'd4, 0, 6'd5, 32'h0,  32'h0,  0, 3'd1);
    add("m_c4",     32'h1F, 32'h1F, p3, 3'd0, 1, 0, 6'd0,  1, 6'd4, 1, 6'd4, 32'h8,  32'h0,  0, 3'd2);
    add("m_i4",     32'h1F, 32'h1F, p3, 3'd0, 0, 0, 6'd0,  1, 6'd3, 0, 6'd4, 32'h0,  32'h0,  0, 3'd2);
    add("m_c3",     32'h1F, 32'h1F, p3, 3'd0, 1, 0, 6'd0,  1, 6'd3, 1, 6'd3, 32'h4,  32'h0,  0, 3'd3);
    add("m_i3",     32'h1F, 32'h1F, p3, 3'd0, 0, 0, 6'd0,  1, 6'd2, 0, 6'd3, 32'h0,  32'h0,  0, 3'd3);
    add("m_c2",     32'h1F, 32'h1F, p3, 3'd0, 1, 0, 6'd0,  1, 6'd2, 1, 6'd2, 32'h2,  32'h0,  0, 3'd4);
    add("m_i2",     32'h1F, 32'h1F, p3, 3'd0, 0, 0, 6'd0,  1, 6'd1, 0, 6'd2, 32'h0,  32'h0,  0, 3'd4);
    add("m_full",   32'h1F, 32'h1F, p3, 3'd0, 1, 0, 6'd0,  1, 6'd1, 1, 6'd0, 32'h0,  32'h0,  0, 3'd4);
    add("m_full_cc",32'h1F, 32'h1F, p3, 3'd0, 1, 1, 6'd5,  1, 6'd1, 1, 6'd0, 32'h0,  32'h10, 0, 3'd3);
    add("m_i_free", 32'h1F, 32'h1F, p3, 3'd0, 0, 0, 6'd0,  1, 6'd5, 0, 6'd0, 32'h0,  32'h0,  0, 3'd3);
    add("m_cc_ok",  32'h1F, 32'h1F, p3, 3'd0, 1, 1, 6'd4,  1, 6'd5, 1, 6'd5, 32'h10, 32'h8,  0, 3'd3);
    add("m_i_end",  32'h1F, 32'h1F, p3, 3'd0, 0, 0, 6'd0,  1, 6'd4, 0, 6'd5, 32'h0,  32'h0,  0, 3'd3);

    // Reset with every input active: reset must win.
    rst = 1'b1; ip = '1; ie = '1; prio = '1; thr = 3'd0;
    cre = 1'b1; cwe = 1'b1; cid = 6'd1;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 6'd0, 0, 6'd0, 32'h0, 32'h0, 0, 3'd0);

    @(negedge clk);
    rst = 1'b0; ip = '0; ie = '0; prio = '0; idle_strobes();

    foreach (vq[k]) begin
      @(negedge clk);
      ip = vq[k].ip; ie = vq[k].ie; prio = vq[k].prio; thr = vq[k].thr;
      cre = vq[k].cre; cwe = vq[k].cwe; cid = vq[k].cid;
      @(posedge clk);
      #1 chk_all(vq[k].nm, vq[k].e_irq, vq[k].e_id, vq[k].e_rv, vq[k].e_rid,
                 vq[k].e_claim, vq[k].e_cmp, vq[k].e_err, vq[k].e_cnt);
    end

    // Claim followed by reset in the next cycle: everything cleared.
    @(negedge clk); cre = 1'b1;
    @(negedge clk); cre = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 chk_all("rst_mid", 0, 6'd0, 0, 6'd0, 32'h0, 32'h0, 0, 3'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    #1 chk_all("rst_rel", 1, 6'd5, 0, 6'd0, 32'h0, 32'h0, 0, 3'd0);

    // Reset coinciding with claim and complete strobes.
    @(negedge clk); rst = 1'b1; cre = 1'b1; cwe = 1'b1; cid = 6'd5;
    @(posedge clk);
    #1 chk_all("rst_same", 0, 6'd0, 0, 6'd0, 32'h0, 32'h0, 0, 3'd0);
    @(negedge clk); rst = 1'b0; idle_strobes();
    @(posedge clk);
    #1 chk_all("rst_rel2", 1, 6'd5, 0, 6'd0, 32'h0, 32'h0, 0, 3'd0);

    // Source 5 claimable again after reset, counter restarts from zero.
    @(negedge clk); cre = 1'b1;
    @(posedge clk);
    #1 chk_all("post_rst_claim", 1, 6'd5, 1, 6'd5, 32'h10, 32'h0, 0, 3'd1);
    @(negedge clk); idle_strobes();
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
